// File: rtl/port_pin_ctrl.sv
// 8051-style quasi-bidirectional port pin stage: latch -> pad controls with a
// strong pull-up pulse on 0->1, synchronised pin read-back and sticky change flags.

// Per-bit drive logic: latch register, pad controls and strong pull-up counter.
module port_pin_bit #(
    parameter int PU_CYCLES = 2
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_latch_in,
    output logic o_latch_q,
    output logic o_drive_low,
    output logic o_weak_pu,
    output logic o_strong_pu
);
    localparam logic [3:0] PU_LOAD = 4'(PU_CYCLES);

    logic       r_latch_q;
    logic       r_drive_low;
    logic       r_weak_pu;
    logic       r_strong_pu;
    logic [3:0] r_cnt;
    logic       w_rise;
    logic       w_fall;

    assign w_rise = i_latch_in & ~r_latch_q;
    assign w_fall = ~i_latch_in & r_latch_q;

    // latch_q tracks latch_in even in reset so release never looks like a rising edge
    always_ff @(posedge i_clock) begin
        r_latch_q <= i_latch_in;
        if (!i_reset) begin
            r_drive_low <= 1'b0;
            r_weak_pu   <= 1'b1;
            r_strong_pu <= 1'b0;
            r_cnt       <= 4'd0;
        end else begin
            r_drive_low <= ~r_latch_q;
            r_weak_pu   <= r_latch_q;
            r_strong_pu <= (r_cnt != 4'd0);
            if (w_rise)
                r_cnt <= PU_LOAD;
            else if (w_fall)
                r_cnt <= 4'd0;
            else if (r_cnt != 4'd0)
                r_cnt <= r_cnt - 4'd1;
        end
    end

    assign o_latch_q   = r_latch_q;
    assign o_drive_low = r_drive_low;
    assign o_weak_pu   = r_weak_pu;
    assign o_strong_pu = r_strong_pu;
endmodule

module port_pin_ctrl #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int PU_CYCLES   = 2
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_latch_in,
    input  logic [WIDTH-1:0] i_pin_in,
    input  logic             i_rd_en,
    input  logic             i_rd_latch,
    input  logic [WIDTH-1:0] i_chg_clr,
    output logic [WIDTH-1:0] o_drive_low,
    output logic [WIDTH-1:0] o_weak_pu,
    output logic [WIDTH-1:0] o_strong_pu,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_rd_valid,
    output logic [WIDTH-1:0] o_pin_change
);
    logic [WIDTH-1:0]                  w_latch_q;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0]                  w_pin_s;
    logic [WIDTH-1:0]                  r_pin_p;
    logic [WIDTH-1:0]                  r_pin_change;
    logic [WIDTH-1:0]                  r_rd_data;
    logic                              r_rd_valid;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            port_pin_bit #(.PU_CYCLES(PU_CYCLES)) u_bit (
                .i_clock     (i_clock),
                .i_reset     (i_reset),
                .i_latch_in  (i_latch_in[gi]),
                .o_latch_q   (w_latch_q[gi]),
                .o_drive_low (o_drive_low[gi]),
                .o_weak_pu   (o_weak_pu[gi]),
                .o_strong_pu (o_strong_pu[gi])
            );
        end
    endgenerate

    assign w_pin_s = r_sync[SYNC_STAGES-1];

    // Synchroniser presets to 1 so an idle pulled-up pin raises no change flag
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_sync       <= '1;
            r_pin_p      <= '1;
            r_pin_change <= '0;
        end else begin
            r_sync       <= {r_sync[SYNC_STAGES-2:0], i_pin_in};
            r_pin_p      <= w_pin_s;
            r_pin_change <= (r_pin_change & ~i_chg_clr) | (w_pin_s ^ r_pin_p);
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= i_rd_en;
            if (i_rd_en)
                r_rd_data <= i_rd_latch ? w_latch_q : w_pin_s;
        end
    end

    assign o_rd_data    = r_rd_data;
    assign o_rd_valid   = r_rd_valid;
    assign o_pin_change = r_pin_change;
endmodule

// File: tb/tb_port_pin_ctrl.sv
// Directed bench for port_pin_ctrl: reset, strong pull-up pulse, read path,
// change flags and reset abort, each with hand-computed expectations.
module tb_port_pin_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] latch_in, pin_in, chg_clr;
    logic       rd_en, rd_latch;
    logic [7:0] drive_low, weak_pu, strong_pu, rd_data, pin_change;
    logic       rd_valid;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    port_pin_ctrl #(.WIDTH(8), .SYNC_STAGES(2), .PU_CYCLES(2)) dut (
        .i_clock(clk), .i_reset(rst), .i_latch_in(latch_in), .i_pin_in(pin_in),
        .i_rd_en(rd_en), .i_rd_latch(rd_latch), .i_chg_clr(chg_clr),
        .o_drive_low(drive_low), .o_weak_pu(weak_pu), .o_strong_pu(strong_pu),
        .o_rd_data(rd_data), .o_rd_valid(rd_valid), .o_pin_change(pin_change)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; latch_in = 8'hFF; pin_in = 8'hFF; chg_clr = 8'h00;
        rd_en = 1'b0; rd_latch = 1'b0;
        tick(); tick();
        checks++;
        if (weak_pu !== 8'hFF || drive_low !== 8'h00 || strong_pu !== 8'h00) begin
            failures++;
            $display("FAIL reset_in: weak=%h dl=%h spu=%h want FF 00 00", weak_pu, drive_low, strong_pu);
        end
        checks++;
        if (rd_data !== 8'h00 || rd_valid !== 1'b0 || pin_change !== 8'h00) begin
            failures++;
            $display("FAIL reset_rd: rd=%h v=%b chg=%h want 00 0 00", rd_data, rd_valid, pin_change);
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (weak_pu !== 8'hFF || strong_pu !== 8'h00 || drive_low !== 8'h00 || pin_change !== 8'h00) begin
                failures++;
                $display("FAIL reset_release[%0d]: weak=%h spu=%h dl=%h chg=%h want FF 00 00 00",
                         i, weak_pu, strong_pu, drive_low, pin_change);
            end
        end
    endtask

    task automatic test_strong_pulse();
        logic [7:0] exp_spu [4];
        logic [7:0] exp_dl [4];
        exp_spu = '{8'h00, 8'hA5, 8'hA5, 8'h00};
        exp_dl  = '{8'hFF, 8'h5A, 8'h5A, 8'h5A};
        latch_in = 8'h00;
        tick(); tick(); tick();
        latch_in = 8'hA5;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (strong_pu !== exp_spu[i] || drive_low !== exp_dl[i]) begin
                failures++;
                $display("FAIL strong_pulse[%0d]: spu=%h dl=%h want %h %h",
                         i, strong_pu, drive_low, exp_spu[i], exp_dl[i]);
            end
        end
        checks++;
        if (weak_pu !== 8'hA5) begin
            failures++;
            $display("FAIL strong_weak: weak=%h want A5", weak_pu);
        end
    endtask

    task automatic test_short_pulse();
        logic [7:0] exp_spu [4];
        logic [7:0] exp_dl [4];
        exp_spu = '{8'h00, 8'h01, 8'h00, 8'h00};
        exp_dl  = '{8'hFF, 8'hFE, 8'hFF, 8'hFF};
        latch_in = 8'h00;
        tick(); tick(); tick();
        latch_in = 8'h01;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) latch_in = 8'h00;
            checks++;
            if (strong_pu !== exp_spu[i] || drive_low !== exp_dl[i] || (strong_pu & drive_low) !== 8'h00) begin
                failures++;
                $display("FAIL short_pulse[%0d]: spu=%h dl=%h want %h %h",
                         i, strong_pu, drive_low, exp_spu[i], exp_dl[i]);
            end
        end
    endtask

    task automatic test_read();
        latch_in = 8'hFF; pin_in = 8'h3C;
        tick(); tick(); tick();
        rd_en = 1'b1; rd_latch = 1'b0;
        tick();
        rd_en = 1'b0;
        checks++;
        if (rd_data !== 8'h3C || rd_valid !== 1'b1) begin
            failures++;
            $display("FAIL read_pin: rd=%h v=%b want 3C 1", rd_data, rd_valid);
        end
        tick();
        checks++;
        if (rd_data !== 8'h3C || rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL read_hold: rd=%h v=%b want 3C 0", rd_data, rd_valid);
        end
        rd_en = 1'b1; rd_latch = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++;
        if (rd_data !== 8'hFF || rd_valid !== 1'b1) begin
            failures++;
            $display("FAIL read_latch: rd=%h v=%b want FF 1", rd_data, rd_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_rd [3];
        exp_rd = '{8'h3C, 8'hFF, 8'h3C};
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd_latch = (i == 1);
            tick();
            checks++;
            if (rd_data !== exp_rd[i] || rd_valid !== 1'b1) begin
                failures++;
                $display("FAIL b2b[%0d]: rd=%h v=%b want %h 1", i, rd_data, rd_valid, exp_rd[i]);
            end
        end
        rd_en = 1'b0;
        tick();
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 8'h3C) begin
            failures++;
            $display("FAIL b2b_end: rd=%h v=%b want 3C 0", rd_data, rd_valid);
        end
    endtask

    task automatic test_pin_change();
        logic [7:0] exp_chg [3];
        exp_chg = '{8'h00, 8'h00, 8'h80};
        pin_in = 8'hBC;
        tick(); tick(); tick(); tick();
        chg_clr = 8'hFF;
        tick();
        chg_clr = 8'h00;
        checks++;
        if (pin_change !== 8'h00) begin
            failures++;
            $display("FAIL chg_clear_all: chg=%h want 00", pin_change);
        end
        pin_in = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (pin_change !== exp_chg[i]) begin
                failures++;
                $display("FAIL chg_latency[%0d]: chg=%h want %h", i, pin_change, exp_chg[i]);
            end
        end
        pin_in = 8'hBC;
        tick(); tick();
        chg_clr = 8'h80;
        tick();
        chg_clr = 8'h00;
        checks++;
        if (pin_change !== 8'h80) begin
            failures++;
            $display("FAIL chg_set_wins: chg=%h want 80", pin_change);
        end
        chg_clr = 8'h80;
        tick();
        chg_clr = 8'h00;
        checks++;
        if (pin_change !== 8'h00) begin
            failures++;
            $display("FAIL chg_clear: chg=%h want 00", pin_change);
        end
    endtask

    task automatic test_reset_mid_pulse();
        latch_in = 8'h00;
        tick(); tick(); tick();
        latch_in = 8'h01;
        tick(); tick();
        checks++;
        if (strong_pu !== 8'h01) begin
            failures++;
            $display("FAIL mid_pulse_start: spu=%h want 01", strong_pu);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (strong_pu !== 8'h00 || weak_pu !== 8'hFF) begin
            failures++;
            $display("FAIL mid_pulse_abort: spu=%h weak=%h want 00 FF", strong_pu, weak_pu);
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (strong_pu !== 8'h00 || weak_pu !== 8'h01 || drive_low !== 8'hFE) begin
                failures++;
                $display("FAIL mid_pulse_after[%0d]: spu=%h weak=%h dl=%h want 00 01 FE",
                         i, strong_pu, weak_pu, drive_low);
            end
        end
    endtask

    initial begin
        test_reset();
        test_strong_pulse();
        test_short_pulse();
        test_read();
        test_back_to_back();
        test_pin_change();
        test_reset_mid_pulse();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
